ehl_ahb_apb_bridge: RTL and testbench

AHB-Lite slave to APB master bridge, sitting downstream of an `ehl_ahb_matrix` slave port (`os_*` / `is_*`). It converts each accepted AHB single transfer into one APB SETUP/ACCESS sequence and returns read data, wait states and error responses to the matrix. The matrix-facing response format is a 2-bit hresp: OKAY=2'b00, ERROR=2'b01.

---
 rtl/ehl_ahb_apb_bridge.sv | 158 +++++++++++++++
 tb/tb_ehl_ahb_apb_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ehl_ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS per accepted AHB transfer.
// Optional ACCESS-phase pready watchdog enabled by defining EHL_AHB_APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready, waiting for a transfer
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready
// ERR1   | first ERROR cycle, hready low
// ERR2   | second ERROR cycle, hready high, may accept next transfer
module ehl_ahb_apb_bridge #(
   parameter int PADDR_W     = 16,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic               hsel,
   input  logic [31:0]        haddr,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [31:0]        hwdata,
   input  logic               hready_in,
   output logic               hready,
   output logic [1:0]         hresp,
   output logic [31:0]        hrdata,
   output logic [PADDR_W-1:0] paddr,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [31:0]        pwdata,
   output logic [3:0]         pstrb,
   input  logic [31:0]        prdata,
   input  logic               pready,
   input  logic               pslverr
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

   state_t               state_q, state_d;
   logic [PADDR_W-1:0]   paddr_q, paddr_d;
   logic                 pwrite_q, pwrite_d;
   logic [2:0]           hsize_q, hsize_d;
   logic [1:0]           alow_q, alow_d;
   logic [31:0]          pwdata_q, pwdata_d;
   logic [31:0]          hrdata_q, hrdata_d;
   logic                 accept;
   logic                 unused_ok;

   assign unused_ok = ^{haddr[31:PADDR_W], htrans[0]};
   assign accept    = hsel & htrans[1] & hready_in;

`ifdef EHL_AHB_APB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        timeout;

   // pready on the terminal edge still completes normally
   assign timeout = (cnt_q == TO_LAST) & ~pready;
`endif

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      hsize_d  = hsize_q;
      alow_d   = alow_q;
      pwdata_d = pwdata_q;
      hrdata_d = hrdata_q;
      case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            if (accept) begin
               paddr_d  = haddr[PADDR_W-1:0];
               pwrite_d = hwrite;
               hsize_d  = hsize;
               alow_d   = haddr[1:0];
               state_d  = (hsize > 3'd2) ? ERR1 : SETUP;
            end
         end
         SETUP: begin
            pwdata_d = hwdata;
            state_d  = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               if (pslverr) begin
                  state_d = ERR1;
               end else begin
                  state_d = IDLE;
                  if (!pwrite_q) hrdata_d = prdata;
               end
            end
`ifdef EHL_AHB_APB_TIMEOUT_EN
            else if (timeout) begin
               state_d = ERR1;
            end
`endif
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

`ifdef EHL_AHB_APB_TIMEOUT_EN
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != ACCESS)  cnt_d = 16'd0;
      else if (!pready)       cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge hclk) begin
      if (hreset) cnt_q <= 16'd0;
      else        cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         hsize_q  <= 3'd0;
         alow_q   <= 2'd0;
         pwdata_q <= 32'd0;
         hrdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         hsize_q  <= hsize_d;
         alow_q   <= alow_d;
         pwdata_q <= pwdata_d;
         hrdata_q <= hrdata_d;
      end
   end

   always_comb begin
      pstrb = 4'b0000;
      if (pwrite_q) begin
         case (hsize_q)
            3'd0:    pstrb = 4'b0001 << alow_q;
            3'd1:    pstrb = alow_q[1] ? 4'b1100 : 4'b0011;
            default: pstrb = 4'b1111;
         endcase
      end
   end

   assign hready  = (state_q == IDLE) | (state_q == ERR2);
   assign hresp   = ((state_q == ERR1) | (state_q == ERR2)) ? 2'b01 : 2'b00;
   assign psel    = (state_q == SETUP) | (state_q == ACCESS);
   assign penable = (state_q == ACCESS);
   assign pwrite  = pwrite_q;
   assign paddr   = paddr_q;
   assign hrdata  = hrdata_q;
   // only combinational data path: hwdata straight through during SETUP
   assign pwdata  = (state_q == SETUP) ? hwdata : pwdata_q;

endmodule

// File: tb/tb_ehl_ahb_apb_bridge.sv
// Directed self-checking bench for ehl_ahb_apb_bridge (TIMEOUT_CYC overridden to 4).
module tb_ehl_ahb_apb_bridge;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready_in;
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic [15:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int checks = 0;
   int errors = 0;

   ehl_ahb_apb_bridge #(.PADDR_W(16), .TIMEOUT_CYC(4)) dut (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
      .hready(hready), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge hclk);
      #1;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = w;
      hsize  = s;
      cycle();
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   logic [31:0] strb_addr [4] = '{32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
   logic [2:0]  strb_size [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
   logic [3:0]  strb_exp  [4] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011};

   initial begin
      int lows;
      int acc;
      hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd0; hwdata = '0; hready_in = 1'b1; prdata = '0; pready = 1'b1;
      pslverr = 1'b0;
      cycle(); cycle();
      check("rst_hready", 32'(hready), 32'd1);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_psel", 32'({psel, penable, pwrite}), 32'd0);
      check("rst_paddr", 32'(paddr), 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_pstrb", 32'(pstrb), 32'd0);
      hreset = 1'b0;
      cycle();

      // zero-wait word write
      addr_phase(32'h1000_0004, 1'b1, 3'd2);
      hwdata = 32'hA000_00BC;
      #1;
      check("wr_setup_ctl", 32'({psel, penable, hready, pwrite}), 32'b1001);
      check("wr_paddr", 32'(paddr), 32'h0004);
      check("wr_pwdata_setup", pwdata, 32'hA000_00BC);
      check("wr_pstrb", 32'(pstrb), 32'hF);
      cycle();
      hwdata = 32'h5555_5555;
      #1;
      check("wr_access_ctl", 32'({psel, penable, hready}), 32'b110);
      check("wr_pwdata_latched", pwdata, 32'hA000_00BC);
      cycle();
      check("wr_done", 32'({hready, hresp, psel}), 32'b1000);
      check("wr_hrdata_kept", hrdata, 32'd0);

      // read with two APB wait states
      pready = 1'b0;
      addr_phase(32'h1000_0010, 1'b0, 3'd2);
      check("rd_pstrb", 32'(pstrb), 32'd0);
      check("rd_paddr", 32'(paddr), 32'h0010);
      lows = 0; acc = 0;
      for (int i = 0; i < 12; i++) begin
         if (hready) break;
         lows++;
         if (penable) begin
            acc++;
            if (acc == 3) begin
               pready = 1'b1;
               prdata = 32'hDADA_1234;
            end
         end
         cycle();
      end
      check("rd_wait_cycles", 32'(lows), 32'd4);
      check("rd_hrdata", hrdata, 32'hDADA_1234);
      check("rd_hresp", 32'(hresp), 32'd0);
      prdata = 32'h0;

      // byte / halfword strobes
      for (int k = 0; k < 4; k++) begin
         addr_phase(strb_addr[k], 1'b1, strb_size[k]);
         check($sformatf("strb%0d", k), 32'(pstrb), 32'(strb_exp[k]));
         cycle(); cycle();
      end

      // slave error, then read pipelined in ERR2
      pslverr = 1'b1;
      addr_phase(32'h1000_0020, 1'b1, 3'd2);
      cycle(); cycle();
      pslverr = 1'b0;
      check("slverr_err1", 32'({hready, hresp, psel}), 32'b0010);
      check("slverr_hrdata_kept", hrdata, 32'hDADA_1234);
      cycle();
      check("slverr_err2", 32'({hready, hresp}), 32'b101);
      prdata = 32'h1234_5678;
      addr_phase(32'h1000_0030, 1'b0, 3'd2);
      check("pipe_setup", 32'({psel, penable, hready, hresp}), 32'b10000);
      check("pipe_paddr", 32'(paddr), 32'h0030);
      cycle(); cycle();
      check("pipe_done", 32'({hready, hresp}), 32'b100);
      check("pipe_hrdata", hrdata, 32'h1234_5678);

      // illegal size: no APB access, two ERROR cycles
      addr_phase(32'h1000_0040, 1'b1, 3'd3);
      check("size_err1", 32'({psel, hready, hresp}), 32'b0001);
      cycle();
      check("size_err2", 32'({psel, hready, hresp}), 32'b0101);
      cycle();
      check("size_idle", 32'({psel, hready, hresp}), 32'b0100);

      // reset during ACCESS
      pready = 1'b0;
      addr_phase(32'h1000_0050, 1'b0, 3'd2);
      cycle();
      check("rstacc_in_access", 32'(penable), 32'd1);
      hreset = 1'b1;
      cycle();
      check("rstacc_state", 32'({psel, penable, hready, hresp}), 32'b00100);
      check("rstacc_hrdata", hrdata, 32'd0);
      hreset = 1'b0;
      cycle();

      // pready held low: watchdog if built in, otherwise wait forever
      addr_phase(32'h1000_0060, 1'b1, 3'd2);
      cycle();
      acc = 0;
      while (penable && acc < 20) begin
         acc++;
         cycle();
      end
`ifdef EHL_AHB_APB_TIMEOUT_EN
      check("to_access_cycles", 32'(acc), 32'd4);
      check("to_err1", 32'({psel, hready, hresp}), 32'b0001);
      cycle();
      check("to_err2", 32'({hready, hresp}), 32'b101);
`else
      check("hold_access_cycles", 32'(acc), 32'd20);
      check("hold_still_access", 32'({psel, penable, hready}), 32'b110);
      pready = 1'b1;
      cycle();
      check("hold_release", 32'({hready, hresp, psel}), 32'b1000);
`endif
      pready = 1'b1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
